// File: rtl/hls_run_ctrl_pkg.sv
// Shared types for the HLS run controller: FSM states, run status codes, default widths.
package hls_run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_START,
    S_WAIT,
    S_REPORT
  } state_e;

  localparam logic [1:0] ST_PASS    = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_NOCHECK = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_RUN_W      = 8;
  localparam int DEF_RST_CYCLES = 2;

  function automatic logic [1:0] result_status(input logic check, input logic match);
    if (!check) return ST_NOCHECK;
    return match ? ST_PASS : ST_FAIL;
  endfunction

endpackage

// File: rtl/hls_cycle_counter.sv
// Saturating latency counter with load-to-one and a terminal compare against a timeout.
module hls_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (load1)                cnt_d = ONE;
    else if (en && (cnt_q != '1))  cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A zero limit means "no timeout", so it never matches.
  assign cnt      = cnt_q;
  assign at_limit = (limit != '0) && (cnt_q == limit);

endmodule

// File: rtl/hls_run_controller.sv
// Multi-run sequencer for a start/done accelerator: resets it, starts it, times it,
// optionally checks its result, and reports one status record per run.
module hls_run_controller
  import hls_run_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RUN_W      = DEF_RUN_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [RUN_W-1:0]  cmd_runs,
  input  logic [CNT_W-1:0]  cmd_timeout,
  input  logic              cmd_check,
  input  logic [DATA_W-1:0] cmd_expected,
  output logic              dut_reset,
  output logic              dut_start_port,
  input  logic              dut_done_port,
  input  logic [DATA_W-1:0] dut_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_status,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [RUN_W-1:0]  res_index,
  output logic              busy
);

  localparam int               RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
  logic [RUN_W-1:0]   runs_q, runs_d;
  logic [RUN_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   timeout_q, timeout_d;
  logic               check_q, check_d;
  logic [DATA_W-1:0]  exp_q, exp_d;
  logic [1:0]         status_q, status_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic               cnt_clr, cnt_load1, cnt_en;
  logic [CNT_W-1:0]   cnt;
  logic               at_limit;
  logic               more_runs;

  hls_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clock),
    .rst_n    (reset),
    .clr      (cnt_clr),
    .load1    (cnt_load1),
    .en       (cnt_en),
    .limit    (timeout_q),
    .cnt      (cnt),
    .at_limit (at_limit)
  );

  // One extra bit so idx+1 cannot wrap before the compare.
  assign more_runs = ({1'b0, idx_q} + {{RUN_W{1'b0}}, 1'b1}) < {1'b0, runs_q};

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    runs_d    = runs_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    check_d   = check_q;
    exp_d     = exp_q;
    status_d  = status_q;
    cycles_d  = cycles_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && !abort) begin
          runs_d    = (cmd_runs == '0) ? RUN_ONE : cmd_runs;
          timeout_d = cmd_timeout;
          check_d   = cmd_check;
          exp_d     = cmd_expected;
          idx_d     = '0;
          rst_cnt_d = '0;
          state_d   = S_DRST;
        end
      end
      S_DRST: begin
        if (rst_cnt_q == RST_LAST) begin
          cnt_load1 = 1'b1;
          state_d   = S_START;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_START, S_WAIT: begin
        cnt_en = 1'b1;
        // Done outranks a timeout landing on the same cycle.
        if (dut_done_port) begin
          status_d = result_status(check_q, dut_result == exp_q);
          cycles_d = cnt;
          state_d  = S_REPORT;
        end else if (at_limit) begin
          status_d = ST_TIMEOUT;
          cycles_d = timeout_q;
          state_d  = S_REPORT;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          if ((status_q != ST_TIMEOUT) && more_runs) begin
            idx_d     = idx_q + RUN_ONE;
            rst_cnt_d = '0;
            state_d   = S_DRST;
          end else begin
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      runs_q    <= '0;
      idx_q     <= '0;
      timeout_q <= '0;
      check_q   <= 1'b0;
      exp_q     <= '0;
      status_q  <= ST_PASS;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      runs_q    <= runs_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      check_q   <= check_d;
      exp_q     <= exp_d;
      status_q  <= status_d;
      cycles_q  <= cycles_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign dut_reset      = (state_q == S_START) || (state_q == S_WAIT);
  assign dut_start_port = (state_q == S_START);
  assign res_valid      = (state_q == S_REPORT);
  assign res_status     = status_q;
  assign res_cycles     = cycles_q;
  assign res_index      = idx_q;

endmodule
